uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
- Serial receiver that sits directly downstream of the team's UART byte transmitter.
- Recovers 8N1 frames from the uart_rx line at one of five selectable baud rates and presents each byte with a one-cycle done strobe.
- Uses a 50 MHz system clock, 16x oversampling and 3-sample majority voting per bit; reports false starts and stop-bit (framing) errors.

Parameters:
- DIV_B0, 325: sample-tick divider terminal count for baud_set 0 (9600 baud, 16x).
- DIV_B1, 162: terminal count for baud_set 1 (19200).
- DIV_B2, 80: terminal count for baud_set 2 (38400).
- DIV_B3, 53: terminal count for baud_set 3 (57600).
- DIV_B4, 26: terminal count for baud_set 4 (115200).

Ports:
- sys_clk  in  1  system clock, 50 MHz; the only clock.
- sys_rst  in  1  reset, asynchronous, active-low.
- uart_rx  in  1  serial line, asynchronous to sys_clk, idles high.
- baud_set  in  3  baud select 0-4; values 5-7 select 9600.
- data_byte  out  8  last received byte, LSB received first.
- rx_done  out  1  one-cycle pulse; data_byte is valid from this cycle onward.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- rx_state  out  1  high while a frame is in progress.

Behaviour:
- Clocking and reset:
  - One clock, sys_clk.
  - sys_rst is asynchronous and active-low; asserting it mid-frame aborts the frame immediately.
  - Reset values: data_byte=0, rx_done=0, frame_err=0, rx_state=0, FSM=IDLE, all counters 0, synchronizer flops=1.
- Input conditioning:
  - uart_rx passes through a 2-flop synchronizer followed by one edge-detect flop.
  - A start is a detected 1->0 transition of the synchronized signal, seen in IDLE only.
- Baud select:
  - baud_set is latched into a divider register on the start detect.
  - Changing baud_set mid-frame has no effect on the current frame.
- Tick generation:
  - The divider counter runs only while rx_state=1 and is cleared to 0 in IDLE.
  - The counter emits a tick when it equals the latched DIV and then wraps to 0, so the tick period is DIV+1 clocks.
  - A 4-bit sub-tick counter (0-15) advances on each tick; 16 ticks make one bit period.
  - Bit samples are taken at sub-ticks 7, 8 and 9, and the bit value is the majority of the 3 samples.
- FSM states:
  - IDLE: rx_state=0. On start detect go to START, set rx_state=1, and clear the divider and sub-tick counters.
  - START: at sub-tick 9, if the majority is 1 (false start / glitch), return to IDLE with rx_state=0 and no pulse. Otherwise continue; at sub-tick 15 go to DATA with bit index 0.
  - DATA: at sub-tick 9, shift the majority into shift[bit index]. At sub-tick 15 increment the bit index; after index 7 go to STOP.
  - STOP:
    - At sub-tick 9, if the majority is 1: load data_byte from the shift register and pulse rx_done on the next clock.
    - If the majority is 0: pulse frame_err, leave data_byte unchanged, and issue no rx_done.
    - In either case return to IDLE with rx_state=0 in the same clock as the pulse. The FSM does not wait for the end of the stop bit, so back-to-back frames are accepted.
- Pulses:
  - rx_done and frame_err are mutually exclusive and are each exactly 1 clock wide.
- Timing:
  - Latency from the mid-stop-bit sample to rx_done is 1 clock.
  - After returning to IDLE, a start edge arriving in the next cycle is accepted.
- Line held low:
  - If the line stays low after a framing error, no new start is detected until a 1->0 edge is seen.
- Tolerance:
  - The receiver tolerates at least ±2% baud mismatch at all five rates.

Test Plan:
- 115200, baud_set=4: send 0x55 with stop=1 -> exactly one rx_done, data_byte=0x55, frame_err never high, rx_state falls in the rx_done cycle.
- 9600, baud_set=0: send 0xA5 then 0x3C with zero idle gap between frames -> two rx_done pulses, data_byte=0xA5 then 0x3C.
- Glitch: uart_rx low for 100 clocks at 115200, then high -> rx_state returns to 0 about 270 clocks after the edge; no rx_done, no frame_err.
- Framing error: 0xF0 at 57600 with the stop bit driven low -> one frame_err pulse, no rx_done, data_byte keeps its prior value.
- Baud select: baud_set=6 with a 9600 frame of 0x81 -> data_byte=0x81. Also change baud_set 4->0 mid-frame -> the frame is still received correctly at 115200.
- Reset: assert sys_rst low in the middle of bit 4 -> all outputs 0 immediately. After release, a fresh frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 16x oversampling with per-frame latched divider,
// 3-sample majority voting per bit, false-start and framing-error detection.
module uart_byte_rx #(
  parameter int unsigned DIV_B0 = 325,
  parameter int unsigned DIV_B1 = 162,
  parameter int unsigned DIV_B2 = 80,
  parameter int unsigned DIV_B3 = 53,
  parameter int unsigned DIV_B4 = 26
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic       sync1_r;
  logic       sync2_r;
  logic       prev_r;
  logic [1:0] state_r;
  logic [8:0] div_lat_r;
  logic [8:0] div_cnt_r;
  logic [3:0] sub_cnt_r;
  logic [2:0] bit_idx_r;
  logic [1:0] samp_r;
  logic [7:0] shift_r;

  logic [8:0] div_sel_s;
  logic       start_s;
  logic       tick_s;
  logic       maj_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Divider selection, start-edge detect, sample tick and bit vote.
  always_comb begin
    case (baud_set)
      3'd1:    div_sel_s = 9'(DIV_B1);
      3'd2:    div_sel_s = 9'(DIV_B2);
      3'd3:    div_sel_s = 9'(DIV_B3);
      3'd4:    div_sel_s = 9'(DIV_B4);
      default: div_sel_s = 9'(DIV_B0);
    endcase
    start_s = (state_r == ST_IDLE) && prev_r && !sync2_r;
    tick_s  = rx_state && (div_cnt_r == div_lat_r);
    maj_s   = maj3(samp_r[0], samp_r[1], sync2_r);
  end

  // Two-flop synchronizer plus edge-detect history; idles high like the line.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Sample-tick divider and 16-step sub-tick counter, held at zero in IDLE.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      div_cnt_r <= 9'd0;
      sub_cnt_r <= 4'd0;
    end else if (state_r == ST_IDLE) begin
      div_cnt_r <= 9'd0;
      sub_cnt_r <= 4'd0;
    end else if (tick_s) begin
      div_cnt_r <= 9'd0;
      sub_cnt_r <= sub_cnt_r + 4'd1;
    end else begin
      div_cnt_r <= div_cnt_r + 9'd1;
    end
  end

  // First two votes of each bit; the third is taken live at sub-tick 9.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      samp_r <= 2'b00;
    end else if (tick_s && (sub_cnt_r == 4'd7)) begin
      samp_r[0] <= sync2_r;
    end else if (tick_s && (sub_cnt_r == 4'd8)) begin
      samp_r[1] <= sync2_r;
    end
  end

  // Frame FSM; stop bit is judged mid-bit so back-to-back frames are caught.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r   <= ST_IDLE;
      rx_state  <= 1'b0;
      div_lat_r <= 9'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      data_byte <= 8'd0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r   <= ST_START;
            rx_state  <= 1'b1;
            div_lat_r <= div_sel_s;
            bit_idx_r <= 3'd0;
          end
        end
        ST_START: begin
          if (tick_s && (sub_cnt_r == 4'd9) && maj_s) begin
            state_r  <= ST_IDLE;
            rx_state <= 1'b0;
          end else if (tick_s && (sub_cnt_r == 4'd15)) begin
            state_r   <= ST_DATA;
            bit_idx_r <= 3'd0;
          end
        end
        ST_DATA: begin
          if (tick_s && (sub_cnt_r == 4'd9)) begin
            shift_r[bit_idx_r] <= maj_s;
          end else if (tick_s && (sub_cnt_r == 4'd15)) begin
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick_s && (sub_cnt_r == 4'd9)) begin
            if (maj_s) begin
              data_byte <= shift_r;
              rx_done   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state_r  <= ST_IDLE;
            rx_state <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          rx_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx; the 9600 divider is shortened so that
// several slow-rate frames fit in a short run.
module tb_uart_byte_rx;

  localparam int D0 = 60;
  localparam int D1 = 162;
  localparam int D2 = 80;
  localparam int D3 = 53;
  localparam int D4 = 26;
  localparam int B0 = 16 * (D0 + 1);
  localparam int B2 = 16 * (D2 + 1);
  localparam int B3 = 16 * (D3 + 1);
  localparam int B4 = 16 * (D4 + 1);

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       uart_rx;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       rx_state;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int exp_done = 0;
  int base_done;
  int base_err;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] exp_q[$];

  uart_byte_rx #(
    .DIV_B0(D0), .DIV_B1(D1), .DIV_B2(D2), .DIV_B3(D3), .DIV_B4(D4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .uart_rx(uart_rx),
    .baud_set(baud_set),
    .data_byte(data_byte),
    .rx_done(rx_done),
    .frame_err(frame_err),
    .rx_state(rx_state)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every rx_done and checks pulse shape.
  always @(negedge sys_clk) begin
    if (rx_done) begin
      check_eq("done_width", prev_done, 1'b0);
      check_eq("done_err_excl", frame_err, 1'b0);
      check_eq("state_at_done", rx_state, 1'b0);
      check_eq("sb_pending", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) check_eq("data_byte", data_byte, exp_q.pop_front());
      done_cnt++;
    end
    if (frame_err) begin
      check_eq("err_width", prev_err, 1'b0);
      err_cnt++;
    end
    prev_done = rx_done;
    prev_err  = frame_err;
  end

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk,
                            input int chg_bit, input logic [2:0] chg_val,
                            input int rst_bit, input logic push);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    if (push) begin
      exp_q.push_back(b);
      exp_done++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      uart_rx = bits[i];
      if (i == chg_bit) baud_set = chg_val;
      if (i == rst_bit) begin
        repeat (bclk / 2) @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check_eq("rst_data_byte", data_byte, 8'h00);
        check_eq("rst_rx_done", rx_done, 1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_rx_state", rx_state, 1'b0);
        repeat (5) @(negedge sys_clk);
        uart_rx = 1'b1;
        sys_rst = 1'b1;
        return;
      end
      repeat (bclk - 1) @(negedge sys_clk);
    end
  endtask

  initial begin
    sys_rst  = 1'b0;
    uart_rx  = 1'b1;
    baud_set = 3'd4;
    repeat (5) @(negedge sys_clk);
    check_eq("init_data_byte", data_byte, 8'h00);
    check_eq("init_rx_done", rx_done, 1'b0);
    check_eq("init_frame_err", frame_err, 1'b0);
    check_eq("init_rx_state", rx_state, 1'b0);
    sys_rst = 1'b1;
    idle(50);

    // 115200 single frame
    base_done = done_cnt;
    send_frame(8'h55, 1'b1, B4, -1, 3'd0, -1, 1'b1);
    idle(B4);
    check_eq("t1_done_cnt", done_cnt - base_done, 1);
    check_eq("t1_err_cnt", err_cnt, 0);

    // 9600 back-to-back
    baud_set  = 3'd0;
    base_done = done_cnt;
    send_frame(8'hA5, 1'b1, B0, -1, 3'd0, -1, 1'b1);
    send_frame(8'h3C, 1'b1, B0, -1, 3'd0, -1, 1'b1);
    idle(B0);
    check_eq("t2_done_cnt", done_cnt - base_done, 2);
    check_eq("t2_last_byte", data_byte, 8'h3C);

    // Glitch: 100 clocks low at 115200
    baud_set  = 3'd4;
    base_done = done_cnt;
    base_err  = err_cnt;
    @(negedge sys_clk);
    uart_rx = 1'b0;
    repeat (100) @(negedge sys_clk);
    uart_rx = 1'b1;
    repeat (150) @(negedge sys_clk);
    check_eq("glitch_busy", rx_state, 1'b1);
    repeat (50) @(negedge sys_clk);
    check_eq("glitch_idle", rx_state, 1'b0);
    check_eq("glitch_no_done", done_cnt - base_done, 0);
    check_eq("glitch_no_err", err_cnt - base_err, 0);
    idle(B4);

    // Framing error at 57600, line left low past the stop sample
    baud_set  = 3'd3;
    base_done = done_cnt;
    base_err  = err_cnt;
    send_frame(8'hF0, 1'b0, B3, -1, 3'd0, -1, 1'b0);
    check_eq("ferr_low_no_start", rx_state, 1'b0);
    idle(B3);
    check_eq("ferr_cnt", err_cnt - base_err, 1);
    check_eq("ferr_no_done", done_cnt - base_done, 0);
    check_eq("ferr_keep_byte", data_byte, 8'h3C);

    // baud_set 6 falls back to the 9600 divider
    baud_set = 3'd6;
    send_frame(8'h81, 1'b1, B0, -1, 3'd0, -1, 1'b1);
    idle(B0);
    check_eq("bs6_byte", data_byte, 8'h81);

    // 38400 frame
    baud_set = 3'd2;
    send_frame(8'h69, 1'b1, B2, -1, 3'd0, -1, 1'b1);
    idle(B2);
    check_eq("b2_byte", data_byte, 8'h69);

    // baud_set changed 4->0 during bit 2 of a 115200 frame
    baud_set = 3'd4;
    send_frame(8'h96, 1'b1, B4, 3, 3'd0, -1, 1'b1);
    idle(B4);
    check_eq("chg_byte", data_byte, 8'h96);
    baud_set = 3'd4;
    idle(10);

    // +/-2% baud mismatch at 115200
    send_frame(8'h5A, 1'b1, 441, -1, 3'd0, -1, 1'b1);
    idle(B4);
    send_frame(8'hA6, 1'b1, 423, -1, 3'd0, -1, 1'b1);
    idle(B4);
    check_eq("tol_byte", data_byte, 8'hA6);

    // Reset in the middle of data bit 4, then a fresh frame
    send_frame(8'h33, 1'b1, B4, -1, 3'd0, 5, 1'b0);
    idle(100);
    check_eq("post_rst_state", rx_state, 1'b0);
    send_frame(8'h7E, 1'b1, B4, -1, 3'd0, -1, 1'b1);
    idle(B4);
    check_eq("post_rst_byte", data_byte, 8'h7E);

    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("done_total", done_cnt, exp_done);
    check_eq("err_total", err_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
